// File: rtl/regfile_pkg.sv
// Shared types, defaults and helpers for the 2-read/1-write register file.
package regfile_pkg;

  localparam int unsigned DATA_W_DEF = 4;
  localparam int unsigned ADDR_W_DEF = 4;
  // Widest entry the parity helper accepts; narrower data is zero-extended.
  localparam int unsigned PAR_MAX_W  = 64;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  // Even-parity bit: data plus this bit always holds an even number of ones.
  function automatic logic even_par(input logic [PAR_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/register_file_2r1w_if.sv
// Datapath-facing bus of the register file; parity signals exist only with REGFILE_PARITY_EN.
interface register_file_2r1w_if
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) ();

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en_a;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [DATA_W-1:0] rd_data_a;
  logic              rd_en_b;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_b;
  logic              clr_req;
  logic              busy;
`ifdef REGFILE_PARITY_EN
  logic              inj_par_err;
  logic              par_err_a;
  logic              par_err_b;
`endif

  modport master (
    output wr_en, wr_addr, wr_data,
    output rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
    output clr_req,
`ifdef REGFILE_PARITY_EN
    output inj_par_err,
    input  par_err_a, par_err_b,
`endif
    input  rd_data_a, rd_data_b, busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
    input  clr_req,
`ifdef REGFILE_PARITY_EN
    input  inj_par_err,
    output par_err_a, par_err_b,
`endif
    output rd_data_a, rd_data_b, busy
  );

endinterface

// File: rtl/regfile_read_port.sv
// One read port: write-first bypass, zero-register masking, output register
// and (with REGFILE_PARITY_EN) the parity check registered alongside the data.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
`ifdef REGFILE_PARITY_EN
  input  logic              mem_par,
  input  logic              wr_par,
  output logic              par_err,
`endif
  output logic [DATA_W-1:0] rd_data
);

  logic              bypass_hit;
  logic              zero_hit;
  logic [DATA_W-1:0] rd_data_d, rd_data_q;
`ifdef REGFILE_PARITY_EN
  logic              par_err_d, par_err_q;
`endif

  // Select the read source (zero / bypassed write / array) and hold when not enabled.
  always_comb begin
    bypass_hit = wr_en && (wr_addr == rd_addr);
    zero_hit   = (ZERO_REG != 0) && (rd_addr == '0);
    rd_data_d  = rd_data_q;
`ifdef REGFILE_PARITY_EN
    par_err_d  = par_err_q;
`endif
    if (rd_en) begin
      if (zero_hit) begin
        rd_data_d = '0;
`ifdef REGFILE_PARITY_EN
        par_err_d = 1'b0;
`endif
      end else if (bypass_hit) begin
        rd_data_d = wr_data;
`ifdef REGFILE_PARITY_EN
        par_err_d = even_par(PAR_MAX_W'(wr_data)) ^ wr_par;
`endif
      end else begin
        rd_data_d = mem_data;
`ifdef REGFILE_PARITY_EN
        par_err_d = even_par(PAR_MAX_W'(mem_data)) ^ mem_par;
`endif
      end
    end
  end

  // Output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
`ifdef REGFILE_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      rd_data_q <= rd_data_d;
`ifdef REGFILE_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end
  end

  assign rd_data = rd_data_q;
`ifdef REGFILE_PARITY_EN
  assign par_err = par_err_q;
`endif

endmodule

// File: rtl/register_file_2r1w.sv
// 2-read/1-write register file with write-first bypass and a background clear engine.
// Optional per-entry even parity is enabled by defining REGFILE_PARITY_EN.
module register_file_2r1w
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned ZERO_REG = 0
) (
  input logic                 clk,
  input logic                 rst,
  register_file_2r1w_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  clr_state_t        state_d, state_q;
  logic [ADDR_W-1:0] clr_ptr_d, clr_ptr_q;
  logic              busy_d, busy_q;

  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] mem_q [DEPTH];

  // Effective write of the cycle: clear write has priority, external write otherwise.
  logic              wen;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  logic [DATA_W-1:0] rd_data_a, rd_data_b;

`ifdef REGFILE_PARITY_EN
  logic [DEPTH-1:0]  par_d, par_q;
  logic              wpar;
  logic              par_err_a, par_err_b;
`endif

  // Clear FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      clr_ptr_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      busy_q    <= busy_d;
    end
  end

  // Clear FSM next state; clr_req during CLEAR is ignored.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.clr_req) state_d = CLEAR;
      CLEAR:   if (clr_ptr_q == ADDR_W'(DEPTH - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Clear FSM outputs: sweep pointer and busy flag.
  always_comb begin
    clr_ptr_d = clr_ptr_q;
    busy_d    = (state_d == CLEAR);
    unique case (state_q)
      IDLE:    if (bus.clr_req) clr_ptr_d = '0;
      CLEAR:   clr_ptr_d = clr_ptr_q + ADDR_W'(1);
      default: clr_ptr_d = '0;
    endcase
  end

  // Write arbitration; external writes are dropped while clearing.
  always_comb begin
    if (state_q == CLEAR) begin
      wen   = 1'b1;
      waddr = clr_ptr_q;
      wdata = '0;
`ifdef REGFILE_PARITY_EN
      wpar  = 1'b0;
`endif
    end else begin
      wen   = bus.wr_en;
      waddr = bus.wr_addr;
      wdata = bus.wr_data;
`ifdef REGFILE_PARITY_EN
      wpar  = even_par(PAR_MAX_W'(bus.wr_data)) ^ bus.inj_par_err;
`endif
    end
    if ((ZERO_REG != 0) && (waddr == '0)) wen = 1'b0;
  end

  // Array next state.
  always_comb begin
    mem_d = mem_q;
    if (wen) mem_d[waddr] = wdata;
`ifdef REGFILE_PARITY_EN
    par_d = par_q;
    if (wen) par_d[waddr] = wpar;
`endif
  end

  // Array storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
`ifdef REGFILE_PARITY_EN
      par_q <= '0;
`endif
    end else begin
      mem_q <= mem_d;
`ifdef REGFILE_PARITY_EN
      par_q <= par_d;
`endif
    end
  end

  regfile_read_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_port_a (
    .clk      (clk),
    .rst      (rst),
    .rd_en    (bus.rd_en_a),
    .rd_addr  (bus.rd_addr_a),
    .mem_data (mem_q[bus.rd_addr_a]),
    .wr_en    (wen),
    .wr_addr  (waddr),
    .wr_data  (wdata),
`ifdef REGFILE_PARITY_EN
    .mem_par  (par_q[bus.rd_addr_a]),
    .wr_par   (wpar),
    .par_err  (par_err_a),
`endif
    .rd_data  (rd_data_a)
  );

  regfile_read_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_port_b (
    .clk      (clk),
    .rst      (rst),
    .rd_en    (bus.rd_en_b),
    .rd_addr  (bus.rd_addr_b),
    .mem_data (mem_q[bus.rd_addr_b]),
    .wr_en    (wen),
    .wr_addr  (waddr),
    .wr_data  (wdata),
`ifdef REGFILE_PARITY_EN
    .mem_par  (par_q[bus.rd_addr_b]),
    .wr_par   (wpar),
    .par_err  (par_err_b),
`endif
    .rd_data  (rd_data_b)
  );

  assign bus.rd_data_a = rd_data_a;
  assign bus.rd_data_b = rd_data_b;
  assign bus.busy      = busy_q;
`ifdef REGFILE_PARITY_EN
  assign bus.par_err_a = par_err_a;
  assign bus.par_err_b = par_err_b;
`endif

endmodule

// File: tb/tb_register_file_2r1w.sv
// Scoreboard bench for register_file_2r1w (ZERO_REG=1); parity cases run with REGFILE_PARITY_EN.
module tb_register_file_2r1w;

  typedef struct packed {
    logic       par;
    logic [3:0] data;
  } exp_t;

  bit clk = 1'b0;
  bit rst = 1'b1;
  always #5 clk = ~clk;

  register_file_2r1w_if #(.DATA_W(4), .ADDR_W(4)) bus ();

  register_file_2r1w #(
    .DATA_W   (4),
    .ADDR_W   (4),
    .ZERO_REG (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  exp_t q_a[$];
  exp_t q_b[$];
  bit   chk_a = 1'b0, chk_b = 1'b0;
  bit   chk_a_p = 1'b0, chk_b_p = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: the check flag travels with the edge that produced the registered output.
  always @(posedge clk) begin
    chk_a_p <= chk_a;
    chk_b_p <= chk_b;
  end

  always @(negedge clk) begin
    exp_t e;
    if (chk_a_p) begin
      if (q_a.size() == 0) check("port_a_queue_underflow", 32'd1, 32'd0);
      else begin
        e = q_a.pop_front();
        check("rd_data_a", 32'(bus.rd_data_a), 32'(e.data));
`ifdef REGFILE_PARITY_EN
        check("par_err_a", 32'(bus.par_err_a), 32'(e.par));
`endif
      end
    end
    if (chk_b_p) begin
      if (q_b.size() == 0) check("port_b_queue_underflow", 32'd1, 32'd0);
      else begin
        e = q_b.pop_front();
        check("rd_data_b", 32'(bus.rd_data_b), 32'(e.data));
`ifdef REGFILE_PARITY_EN
        check("par_err_b", 32'(bus.par_err_b), 32'(e.par));
`endif
      end
    end
  end

  task automatic idle();
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.rd_en_a   = 1'b0;
    bus.rd_addr_a = '0;
    bus.rd_en_b   = 1'b0;
    bus.rd_addr_b = '0;
    bus.clr_req   = 1'b0;
`ifdef REGFILE_PARITY_EN
    bus.inj_par_err = 1'b0;
`endif
    chk_a = 1'b0;
    chk_b = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic wr(input int addr, input int data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 4'(addr);
    bus.wr_data = 4'(data);
  endtask

  task automatic rd_a(input int addr, input int exp_data, input bit exp_par);
    bus.rd_en_a   = 1'b1;
    bus.rd_addr_a = 4'(addr);
    chk_a = 1'b1;
    q_a.push_back('{par: exp_par, data: 4'(exp_data)});
  endtask

  task automatic rd_b(input int addr, input int exp_data, input bit exp_par);
    bus.rd_en_b   = 1'b1;
    bus.rd_addr_b = 4'(addr);
    chk_b = 1'b1;
    q_b.push_back('{par: exp_par, data: 4'(exp_data)});
  endtask

  // Expect port A to show a value without issuing a read (reset value or hold).
  task automatic expect_a(input int exp_data);
    chk_a = 1'b1;
    q_a.push_back('{par: 1'b0, data: 4'(exp_data)});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    idle();

    // Reset: outputs go to zero.
    rst = 1'b1;
    step();
    rst = 1'b1;
    expect_a(0);
    chk_b = 1'b1;
    q_b.push_back('{par: 1'b0, data: 4'h0});
    step();
    rst = 1'b0;
    check("busy_after_reset", 32'(bus.busy), 32'd0);

    // Reads after reset return 0.
    rd_a(3, 0, 0);
    rd_b(9, 0, 0);
    step();

    // Write then read with 1-cycle latency, then hold.
    wr(5, 'hA);
    step();
    rd_a(5, 'hA, 0);
    step();
    expect_a('hA);
    step();

    // Same-cycle write and dual read: write-first bypass on both ports.
    wr(2, 'h7);
    rd_a(2, 'h7, 0);
    rd_b(2, 'h7, 0);
    step();
    rd_a(2, 'h7, 0);
    rd_b(5, 'hA, 0);
    step();

    // Zero register: write dropped, including for bypass.
    wr(0, 'hF);
    rd_a(0, 0, 0);
    rd_b(0, 0, 0);
    step();
    rd_b(0, 0, 0);
    step();

`ifdef REGFILE_PARITY_EN
    // Injected parity error is stored and reported on read.
    wr(4, 'h3);
    bus.inj_par_err = 1'b1;
    step();
    rd_a(4, 'h3, 1);
    step();
    wr(4, 'h3);
    step();
    rd_a(4, 'h3, 0);
    step();
    // Bypassed read reports the inverted parity being written.
    wr(8, 'h6);
    bus.inj_par_err = 1'b1;
    rd_b(8, 'h6, 1);
    step();
    rd_b(8, 'h6, 1);
    step();
`endif

    // Fill all entries with their own index.
    for (int i = 0; i < 16; i++) begin
      wr(i, i);
      step();
    end
    for (int i = 0; i < 16; i++) begin
      rd_a(i, i, 0);
      rd_b(15 - i, 15 - i, 0);
      step();
    end

    // Background clear: busy for exactly 16 cycles, writes dropped, reads bypass the clear.
    bus.clr_req = 1'b1;
    step();
    busy_cnt = 0;
    for (int i = 0; i < 24; i++) begin
      if (bus.busy === 1'b1) busy_cnt++;
      if (i == 3) bus.clr_req = 1'b1;
      if (i == 5) wr(1, 'hC);
      if (i == 6) begin
        rd_a(6, 0, 0);
        rd_b(10, 10, 0);
      end
      step();
    end
    check("busy_cycles", 32'(busy_cnt), 32'd16);
    check("busy_after_clear", 32'(bus.busy), 32'd0);
    for (int i = 0; i < 16; i++) begin
      rd_a(i, 0, 0);
      rd_b(15 - i, 0, 0);
      step();
    end

    // Reset in the middle of a clear.
    wr(14, 'hE);
    step();
    wr(15, 'hF);
    step();
    bus.clr_req = 1'b1;
    step();
    for (int i = 0; i < 8; i++) step();
    check("busy_mid_clear", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    rd_a(14, 0, 0);
    step();
    rst = 1'b0;
    check("busy_after_mid_reset", 32'(bus.busy), 32'd0);
    rd_a(14, 0, 0);
    rd_b(15, 0, 0);
    step();
    step();
    check("busy_stays_low", 32'(bus.busy), 32'd0);

    // Write works again after reset.
    wr(14, 'h9);
    step();
    rd_a(14, 'h9, 0);
    step();
    step();
    step();

    check("queue_a_drained", 32'(q_a.size()), 32'd0);
    check("queue_b_drained", 32'(q_b.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
